scan_display_ctrl: RTL and testbench
====================================

Name: scan_display_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit common-anode 7-segment display.
- Divides the system clock into digit slots and rotates the active-low anode one-hot 0→1→2→3→0.
- Inserts a blanking dead-time at the start of each slot to prevent ghosting, decodes hex nibbles to active-low segments, and applies optional leading-zero blanking.
- Holds a double-buffered display value. A new value is committed only at a frame boundary, so a frame never shows a mix of old and new digits.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot; legal range is 2 to 2^CNT_W.
BLANK_CYC, 500, cycles at the start of each slot with all anodes off; must be less than SCAN_DIV; 0 disables dead-time.
CNT_W, 16, prescaler counter width.

Ports:
iClk  in  1  system clock, rising edge
iReset  in  1  asynchronous, active-high reset
iEnable  in  1  scan enable; low turns the display dark and freezes scanning
iLoad  in  1  single-cycle strobe; captures ivValue/ivDp into the shadow register
ivValue  in  16  four hex digits; digit0=[3:0] … digit3=[15:12]
ivDp  in  4  decimal points; bit n belongs to digit n, 1=lit
iLzb  in  1  leading-zero blanking enable
ovAnode  out  4  active-low anode select; bit n drives digit n
ovSeg  out  7  active-low segments {g,f,e,d,c,b,a}
oDp  out  1  active-low decimal point
oPending  out  1  shadow holds an uncommitted value
oLoadAck  out  1  one-cycle pulse when shadow is committed to active
oFrameTick  out  1  one-cycle pulse at the end of the digit-3 slot

Behaviour:
Registering:
- All outputs are registered; there is no combinational path from any input to any output.
- Async reset takes effect immediately, including mid-slot.

Reset values:
- Outputs: ovAnode=4'b1111, ovSeg=7'h7F, oDp=1, oPending=0, oLoadAck=0, oFrameTick=0.
- Internal state: state=BLANK, digit index=0, prescaler=0, active value=0, shadow value=0, active/shadow DP=0.

Prescaler:
- While iEnable=1, counts 0..SCAN_DIV-1 and wraps.
- Slot end is the cycle where cnt==SCAN_DIV-1.

State machine (two states):
- BLANK when cnt<BLANK_CYC; DRIVE otherwise.
- BLANK: ovAnode=1111, ovSeg=7F, oDp=1.
- DRIVE: ovAnode has bit[idx] low and all other bits high; ovSeg is the decode of active nibble[idx]; oDp=~activeDp[idx].
- Output registers update on the same edge as state and index, so every slot gives exactly SCAN_DIV-BLANK_CYC DRIVE cycles.

Slot end:
- idx advances (3 wraps to 0) and the next cycle is BLANK, or DRIVE if BLANK_CYC=0.

Frame boundary (slot end with idx==3):
- oFrameTick pulses.
- If oPending=1: active<=shadow, oPending<=0, and oLoadAck pulses in the same cycle.

Load:
- iLoad=1 sets shadow<=ivValue, shadowDp<=ivDp, oPending<=1.
- Multiple loads in one frame: the last one wins and only one ack is issued.
- iLoad on a frame-boundary cycle: ivValue/ivDp commit directly to active, oPending=0, and oLoadAck pulses.

Decode (hex, active-low):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110

Leading-zero blanking (iLzb=1, evaluated on the active value):
- digit3 is dark if nib3==0.
- digit2 is dark if nib3 and nib2 are both 0.
- digit1 is dark if nib3, nib2 and nib1 are all 0.
- digit0 is never dark.
- A dark digit keeps ovAnode=1111, ovSeg=7F and oDp=1 during its DRIVE cycles.

iEnable:
- iEnable=0 forces BLANK outputs, holds cnt=0 and holds idx.
- No oFrameTick and no commit occur while disabled; loads still update the shadow.
- On re-enable, scanning resumes with a full slot at the held idx, starting in BLANK.

Test Plan:
1. SCAN_DIV=8, BLANK_CYC=2, iEnable=1, value 0 → ovAnode sequence 1110,1101,1011,0111; each digit low for 6 cycles and preceded by 2 cycles of 1111; ovSeg=1000000 while driving; oFrameTick once every 32 cycles.
2. iLoad with 16'h12AF during the idx1 slot → oPending=1 and the display is unchanged until the idx3 slot end. oLoadAck and oFrameTick pulse together. The next frame shows digit0 0001110, digit1 0001000, digit2 0100100, digit3 1111001.
3. iLzb=1, value 16'h0070, ivDp=4'b0001 → digit3 and digit2 stay 1111 throughout their slots; digit1 shows 1111000; digit0 shows 1000000 with oDp=0.
4. Loads 16'h1111 then 16'h2222 in the same frame → one oLoadAck, and 2222 is displayed. iLoad 16'h3333 on the boundary cycle → commits immediately, oPending=0, oLoadAck=1 on that cycle.
5. iEnable=0 for 20 cycles while driving idx2 → ovAnode=1111, no oFrameTick. After re-enable: 2 BLANK cycles, then 6 cycles of 1011.
6. iReset pulsed mid-DRIVE at idx2 with a load pending → ovAnode=1111, ovSeg=7F, oPending=0 immediately (before the next clock edge). After release, scanning restarts at idx0 with a zero value.

Source files
------------

// File: rtl/scan_display_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Rotates one digit per slot, blanks the start of every slot, and swaps in new values only on frame boundaries.
module scan_display_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int CNT_W     = 16
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iEnable,
  input  logic        iLoad,
  input  logic [15:0] ivValue,
  input  logic [3:0]  ivDp,
  input  logic        iLzb,
  output logic [3:0]  ovAnode,
  output logic [6:0]  ovSeg,
  output logic        oDp,
  output logic        oPending,
  output logic        oLoadAck,
  output logic        oFrameTick
);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] LP_BLANK = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_act, r_sh;
  logic [3:0]       r_act_dp, r_sh_dp;

  logic             w_slot_end, w_frame, w_commit, w_dark, w_dp_bit;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_idx_nxt;
  logic [15:0]      w_act_nxt;
  logic [3:0]       w_act_dp_nxt, w_nib, w_anode;
  logic [0:0]       w_state_nxt;
  logic [6:0]       w_seg;

  function automatic logic [6:0] f_seg(input logic [3:0] n);
    case (n)
      4'h0: f_seg = 7'b1000000;
      4'h1: f_seg = 7'b1111001;
      4'h2: f_seg = 7'b0100100;
      4'h3: f_seg = 7'b0110000;
      4'h4: f_seg = 7'b0011001;
      4'h5: f_seg = 7'b0010010;
      4'h6: f_seg = 7'b0000010;
      4'h7: f_seg = 7'b1111000;
      4'h8: f_seg = 7'b0000000;
      4'h9: f_seg = 7'b0010000;
      4'hA: f_seg = 7'b0001000;
      4'hB: f_seg = 7'b0000011;
      4'hC: f_seg = 7'b1000110;
      4'hD: f_seg = 7'b0100001;
      4'hE: f_seg = 7'b0000110;
      default: f_seg = 7'b0001110;
    endcase
  endfunction

  assign w_slot_end = iEnable && (r_cnt == LP_LAST);
  assign w_frame    = w_slot_end && (r_idx == 2'd3);
  assign w_cnt_nxt  = (!iEnable || w_slot_end) ? '0 : r_cnt + 1'b1;
  assign w_idx_nxt  = w_slot_end ? r_idx + 2'd1 : r_idx;

  // A load landing exactly on the boundary bypasses the shadow.
  assign w_commit     = w_frame && (iLoad || oPending);
  assign w_act_nxt    = !w_commit ? r_act    : (iLoad ? ivValue : r_sh);
  assign w_act_dp_nxt = !w_commit ? r_act_dp : (iLoad ? ivDp    : r_sh_dp);

  // Outputs are computed from next-cycle state so they line up with r_cnt/r_idx.
  assign w_state_nxt = (iEnable && (w_cnt_nxt >= LP_BLANK)) ? ST_DRIVE : ST_BLANK;
  assign w_anode     = ~(4'b0001 << w_idx_nxt);
  assign w_dp_bit    = w_act_dp_nxt[w_idx_nxt];
  assign w_seg       = f_seg(w_nib);

  always_comb begin
    w_nib  = w_act_nxt[3:0];
    w_dark = 1'b0;
    case (w_idx_nxt)
      2'd0: w_nib = w_act_nxt[3:0];
      2'd1: begin
        w_nib  = w_act_nxt[7:4];
        w_dark = (w_act_nxt[15:4] == 12'h000);
      end
      2'd2: begin
        w_nib  = w_act_nxt[11:8];
        w_dark = (w_act_nxt[15:8] == 8'h00);
      end
      default: begin
        w_nib  = w_act_nxt[15:12];
        w_dark = (w_act_nxt[15:12] == 4'h0);
      end
    endcase
    w_dark = w_dark && iLzb;
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_cnt      <= '0;
      r_idx      <= 2'd0;
      r_act      <= 16'h0;
      r_act_dp   <= 4'h0;
      r_sh       <= 16'h0;
      r_sh_dp    <= 4'h0;
      ovAnode    <= 4'b1111;
      ovSeg      <= 7'h7F;
      oDp        <= 1'b1;
      oPending   <= 1'b0;
      oLoadAck   <= 1'b0;
      oFrameTick <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_act    <= w_act_nxt;
      r_act_dp <= w_act_dp_nxt;
      if (iLoad) begin
        r_sh    <= ivValue;
        r_sh_dp <= ivDp;
      end
      oPending   <= w_commit ? 1'b0 : (iLoad ? 1'b1 : oPending);
      oLoadAck   <= w_commit;
      oFrameTick <= w_frame;
      if (w_state_nxt == ST_DRIVE && !w_dark) begin
        ovAnode <= w_anode;
        ovSeg   <= w_seg;
        oDp     <= ~w_dp_bit;
      end else begin
        ovAnode <= 4'b1111;
        ovSeg   <= 7'h7F;
        oDp     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Scoreboard bench for scan_display_ctrl: stimulus pushes expected outputs per cycle, a negedge monitor pops and compares.
module tb_scan_display_ctrl;
  localparam int SD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, ld = 1'b0, lzb = 1'b0;
  logic [15:0] val = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  ovAnode;
  logic [6:0]  ovSeg;
  logic        oDp, oPending, oLoadAck, oFrameTick;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp, pend, ack, tick;
  } exp_t;

  exp_t q[$];
  int errs = 0, checks = 0;

  logic [6:0] SEG [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference state: slot position, digit on display, committed and shadow values.
  int          m_pos, m_dig;
  logic [15:0] m_act, m_sh;
  logic [3:0]  m_actdp, m_shdp;
  logic        m_pend;

  scan_display_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .CNT_W(4)) dut (
    .iClk(clk), .iReset(rst), .iEnable(en), .iLoad(ld), .ivValue(val), .ivDp(dp),
    .iLzb(lzb), .ovAnode(ovAnode), .ovSeg(ovSeg), .oDp(oDp), .oPending(oPending),
    .oLoadAck(oLoadAck), .oFrameTick(oFrameTick));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_dig = 0; m_act = 16'h0; m_sh = 16'h0;
    m_actdp = 4'h0; m_shdp = 4'h0; m_pend = 1'b0;
    q.delete();
  endtask

  task automatic model_step();
    exp_t e;
    logic [3:0] nib;
    logic dark;
    e.ack = 1'b0; e.tick = 1'b0;
    if (ld) begin m_sh = val; m_shdp = dp; end
    if (en) begin
      if (m_pos == SD-1 && m_dig == 3) begin
        e.tick = 1'b1;
        if (ld || m_pend) begin
          m_act = m_sh; m_actdp = m_shdp; m_pend = 1'b0; e.ack = 1'b1;
        end
      end else if (ld) m_pend = 1'b1;
      m_pos++;
      if (m_pos == SD) begin m_pos = 0; m_dig = (m_dig + 1) % 4; end
    end else begin
      m_pos = 0;
      if (ld) m_pend = 1'b1;
    end
    nib  = 4'((m_act >> (4*m_dig)) & 16'hF);
    dark = lzb && m_dig > 0 && ((m_act >> (4*m_dig)) == 0);
    if (en && m_pos >= BC && !dark) begin
      e.an = 4'hF ^ 4'(1 << m_dig); e.seg = SEG[nib]; e.dp = ~m_actdp[m_dig];
    end else begin
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
    end
    e.pend = m_pend;
    q.push_back(e);
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick_cycle();
  endtask

  task automatic wait_for(input int pos, input int dig);
    int k;
    k = 0;
    while (!(m_pos == pos && m_dig == dig) && k < 200) begin tick_cycle(); k++; end
    chk("wait_bound", int'(k < 200), 1);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    ld = 1'b1; val = v; dp = d;
    tick_cycle();
    ld = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst || q.size() == 0) begin
        chk("rst_anode", int'(ovAnode), 'hF);
        chk("rst_seg", int'(ovSeg), 'h7F);
        chk("rst_dp", int'(oDp), 1);
        chk("rst_pend", int'(oPending), 0);
        chk("rst_ack", int'(oLoadAck), 0);
        chk("rst_tick", int'(oFrameTick), 0);
      end else begin
        e = q.pop_front();
        chk("anode", int'(ovAnode), int'(e.an));
        chk("seg", int'(ovSeg), int'(e.seg));
        chk("dp", int'(oDp), int'(e.dp));
        chk("pending", int'(oPending), int'(e.pend));
        chk("loadack", int'(oLoadAck), int'(e.ack));
        chk("frametick", int'(oFrameTick), int'(e.tick));
      end
    end
  end

  initial begin
    model_reset();
    run(3);
    rst = 1'b0;
    // Plain scan of zero value
    en = 1'b1;
    run(70);
    // Load during idx1, committed at the frame boundary
    wait_for(3, 1);
    load(16'h12AF, 4'h0);
    run(70);
    // Leading-zero blanking with a lit DP on digit0
    lzb = 1'b1;
    wait_for(3, 0);
    load(16'h0070, 4'b0001);
    run(70);
    // Two loads in one frame, then a load exactly on the boundary
    lzb = 1'b0;
    wait_for(3, 0);
    load(16'h1111, 4'h2);
    run(3);
    load(16'h2222, 4'h4);
    run(70);
    wait_for(SD-1, 3);
    load(16'h3333, 4'h8);
    run(40);
    // Disable while driving idx2
    wait_for(4, 2);
    en = 1'b0;
    run(20);
    en = 1'b1;
    run(40);
    // Async reset mid-DRIVE with a load pending
    wait_for(2, 1);
    load(16'hBEEF, 4'hF);
    wait_for(4, 2);
    @(posedge clk);
    model_step();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_anode", int'(ovAnode), 'hF);
    chk("async_seg", int'(ovSeg), 'h7F);
    chk("async_pend", int'(oPending), 0);
    run(2);
    rst = 1'b0;
    run(40);
    // Random traffic
    repeat (800) begin
      en  = ($urandom_range(0, 19) != 0);
      ld  = ($urandom_range(0, 9) == 0);
      val = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp  = 4'($urandom);
      if ($urandom_range(0, 49) == 0) lzb = ~lzb;
      tick_cycle();
    end
    ld = 1'b0;
    run(2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
